// File: rtl/mac_tree_pipe.sv
// Pipelined multiply-accumulate tree: registered per-tap products, one adder level
// per stage, then a saturating accumulator/output register behind a valid/ready stall.

module mac_tree_lane #(
   parameter int DATA_WIDTH  = 8,
   parameter int COEFF_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              en,
   input  logic [DATA_WIDTH-1:0]             data,
   input  logic [COEFF_WIDTH-1:0]            coeff,
   output logic [DATA_WIDTH+COEFF_WIDTH-1:0] prod
);
   localparam int P = DATA_WIDTH + COEFF_WIDTH;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   prod <= '0;
      else if (en) prod <= P'(data) * P'(coeff);
   end
endmodule

module mac_tree_pipe #(
   parameter int DATA_WIDTH  = 8,
   parameter int COEFF_WIDTH = 8,
   parameter int N_TAPS      = 4,
   parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS) + 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_TAPS*DATA_WIDTH-1:0]  data_in,
   input  logic [N_TAPS*COEFF_WIDTH-1:0] coeff_in,
   input  logic                          acc_mode,
   input  logic                          acc_clear,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_WIDTH-1:0]          result,
   output logic                          overflow
);
   localparam int LEVELS  = $clog2(N_TAPS);
   localparam int P       = DATA_WIDTH + COEFF_WIDTH;
   localparam int S       = P + LEVELS;
   localparam int TREE_ST = LEVELS + 1;

   logic               stall;
   logic               accept;
   logic [TREE_ST:1]   vld_pipe, mode_pipe, clr_pipe;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   // Sideband travels with every slot, bubbles included, so it always lines up with vld_pipe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe  <= '0;
         mode_pipe <= '0;
         clr_pipe  <= '0;
      end else if (!stall) begin
         vld_pipe  <= {vld_pipe[TREE_ST-1:1], accept};
         mode_pipe <= {mode_pipe[TREE_ST-1:1], acc_mode};
         clr_pipe  <= {clr_pipe[TREE_ST-1:1], acc_clear};
      end
   end

   // Level l holds N_TAPS>>l partial sums, each one bit wider than the level before.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int NW = N_TAPS >> l;
      logic [NW-1:0][P+l-1:0] sum;

      if (l == 0) begin : g_mul
         for (genvar k = 0; k < NW; k++) begin : g_lane
            mac_tree_lane #(
               .DATA_WIDTH (DATA_WIDTH),
               .COEFF_WIDTH(COEFF_WIDTH)
            ) u_lane (
               .clk  (clk),
               .reset(reset),
               .en   (~stall),
               .data (data_in[k*DATA_WIDTH +: DATA_WIDTH]),
               .coeff(coeff_in[k*COEFF_WIDTH +: COEFF_WIDTH]),
               .prod (sum[k])
            );
         end
      end else begin : g_add
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sum <= '0;
            else if (!stall)
               for (int k = 0; k < NW; k++)
                  sum[k] <= {1'b0, g_lvl[l-1].sum[2*k]} + {1'b0, g_lvl[l-1].sum[2*k+1]};
         end
      end
   end

   logic [S-1:0]         tree_out;
   logic [ACC_WIDTH-1:0] sum_ext;
   logic [ACC_WIDTH:0]   acc_full;

   assign tree_out = g_lvl[LEVELS].sum[0];
   assign sum_ext  = ACC_WIDTH'(tree_out);
   assign acc_full = {1'b0, result} + {1'b0, sum_ext};

   // result is the running total: bubbles leave it alone so the next accumulate adds onto it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
      end else if (!stall) begin
         out_valid <= vld_pipe[TREE_ST];
         if (vld_pipe[TREE_ST]) begin
            if (!mode_pipe[TREE_ST] || clr_pipe[TREE_ST]) begin
               result   <= sum_ext;
               overflow <= 1'b0;
            end else if (acc_full[ACC_WIDTH]) begin
               result   <= '1;
               overflow <= 1'b1;
            end else begin
               result   <= acc_full[ACC_WIDTH-1:0];
            end
         end
      end
   end
endmodule
